// File: rtl/rob_pkg.sv
// Shared types and default parameters for the circular reorder buffer.
// Per-entry status is kept separate from the instr/val payload storage.
package rob_pkg;

  localparam int DEF_DEPTH   = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_CPL = 2;

  typedef struct packed {
    logic valid;
    logic ready;
    logic exc;
  } entry_state_t;

  localparam entry_state_t ENTRY_FREE = '{valid: 1'b0, ready: 1'b0, exc: 1'b0};
  localparam entry_state_t ENTRY_NEW  = '{valid: 1'b1, ready: 1'b0, exc: 1'b0};

endpackage

// File: rtl/rob_cpl_arb.sv
// Per-entry completion match across all completion ports.
// When several ports target the same entry, the highest-numbered port wins.
module rob_cpl_arb #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_CPL = 2
) (
  input  logic [NUM_CPL-1:0]              cpl_valid,
  input  logic [NUM_CPL*TAG_W-1:0]        cpl_tag,
  input  logic [NUM_CPL*DATA_W-1:0]       cpl_val,
  input  logic [NUM_CPL-1:0]              cpl_exc,
  output logic [DEPTH-1:0]                hit,
  output logic [DEPTH-1:0][DATA_W-1:0]    hit_val,
  output logic [DEPTH-1:0]                hit_exc
);

  logic match_s;

  // Scan ports in ascending order so later (higher) ports overwrite earlier ones.
  always_comb begin
    hit     = '0;
    hit_val = '0;
    hit_exc = '0;
    match_s = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int k = 0; k < NUM_CPL; k++) begin
        match_s    = cpl_valid[k] && (cpl_tag[k*TAG_W +: TAG_W] == TAG_W'(e));
        hit[e]     = hit[e] | match_s;
        hit_val[e] = match_s ? cpl_val[k*DATA_W +: DATA_W] : hit_val[e];
        hit_exc[e] = match_s ? cpl_exc[k] : hit_exc[e];
      end
    end
  end

endmodule

// File: rtl/rob_circ.sv
// Circular reorder buffer: in-order allocate/retire, out-of-order completion.
// Head/tail carry an extra wrap bit so full and empty are distinguishable.
module rob_circ
  import rob_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_CPL = DEF_NUM_CPL,
  localparam int TAG_W  = $clog2(DEPTH),
  localparam int CNT_W  = TAG_W + 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [DATA_W-1:0]           instr_in,
  output logic [TAG_W-1:0]            alloc_tag,
  output logic                        push_ok,
  input  logic [NUM_CPL-1:0]          cpl_valid,
  input  logic [NUM_CPL*TAG_W-1:0]    cpl_tag,
  input  logic [NUM_CPL*DATA_W-1:0]   cpl_val,
  input  logic [NUM_CPL-1:0]          cpl_exc,
  input  logic                        pop,
  output logic                        pop_ok,
  input  logic                        flush,
  output logic [DATA_W-1:0]           head_instr,
  output logic [DATA_W-1:0]           head_val,
  output logic                        head_ready,
  output logic                        head_exc,
  output logic [TAG_W-1:0]            head_tag,
  output logic                        is_full,
  output logic                        is_empty,
  output logic [CNT_W-1:0]            count
);

  entry_state_t              state_r [DEPTH];
  logic [DATA_W-1:0]         instr_r [DEPTH];
  logic [DATA_W-1:0]         val_r   [DEPTH];
  logic [CNT_W-1:0]          head_r;
  logic [CNT_W-1:0]          tail_r;

  logic [TAG_W-1:0]          head_idx_s;
  logic [TAG_W-1:0]          tail_idx_s;
  entry_state_t              head_state_s;
  logic [DEPTH-1:0]          cpl_hit_s;
  logic [DEPTH-1:0][DATA_W-1:0] cpl_hit_val_s;
  logic [DEPTH-1:0]          cpl_hit_exc_s;

  rob_cpl_arb #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W),
    .NUM_CPL (NUM_CPL)
  ) u_cpl_arb (
    .cpl_valid (cpl_valid),
    .cpl_tag   (cpl_tag),
    .cpl_val   (cpl_val),
    .cpl_exc   (cpl_exc),
    .hit       (cpl_hit_s),
    .hit_val   (cpl_hit_val_s),
    .hit_exc   (cpl_hit_exc_s)
  );

  assign head_idx_s   = head_r[TAG_W-1:0];
  assign tail_idx_s   = tail_r[TAG_W-1:0];
  assign head_state_s = state_r[head_idx_s];

  assign is_empty  = (head_r == tail_r);
  assign is_full   = (head_idx_s == tail_idx_s) && (head_r[TAG_W] != tail_r[TAG_W]);
  assign count     = tail_r - head_r;
  assign alloc_tag = tail_idx_s;

  // Everything at the head reads as zero while empty, since payload is unreset.
  assign head_ready = !is_empty && head_state_s.ready;
  assign head_exc   = !is_empty && head_state_s.exc;
  assign head_tag   = is_empty ? {TAG_W{1'b0}}  : head_idx_s;
  assign head_instr = is_empty ? {DATA_W{1'b0}} : instr_r[head_idx_s];
  assign head_val   = is_empty ? {DATA_W{1'b0}} : val_r[head_idx_s];

  assign push_ok = push && !is_full && !flush;
  assign pop_ok  = pop && head_ready && !flush;

  // Pointers and entry status; pop is applied after completions so it wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r <= '0;
      tail_r <= '0;
      for (int e = 0; e < DEPTH; e++) state_r[e] <= ENTRY_FREE;
    end else if (flush) begin
      head_r <= '0;
      tail_r <= '0;
      for (int e = 0; e < DEPTH; e++) state_r[e] <= ENTRY_FREE;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (cpl_hit_s[e] && state_r[e].valid) begin
          state_r[e].ready <= 1'b1;
          state_r[e].exc   <= cpl_hit_exc_s[e];
        end
      end
      if (push_ok) begin
        state_r[tail_idx_s] <= ENTRY_NEW;
        tail_r              <= tail_r + CNT_W'(1);
      end
      if (pop_ok) begin
        state_r[head_idx_s] <= ENTRY_FREE;
        head_r              <= head_r + CNT_W'(1);
      end
    end
  end

  // Payload storage; stale contents are masked by the valid bits.
  always_ff @(posedge clock) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (cpl_hit_s[e] && state_r[e].valid) val_r[e] <= cpl_hit_val_s[e];
    end
    if (push_ok) begin
      instr_r[tail_idx_s] <= instr_in;
      val_r[tail_idx_s]   <= {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_rob_circ.sv
// Self-checking bench for rob_circ (DEPTH=4): directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_rob_circ;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int NUM_CPL = 2;
  localparam int TAG_W   = 2;
  localparam int CNT_W   = 3;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic                      push;
  logic [DATA_W-1:0]         instr_in;
  logic [TAG_W-1:0]          alloc_tag;
  logic                      push_ok;
  logic [NUM_CPL-1:0]        cpl_valid;
  logic [NUM_CPL*TAG_W-1:0]  cpl_tag;
  logic [NUM_CPL*DATA_W-1:0] cpl_val;
  logic [NUM_CPL-1:0]        cpl_exc;
  logic                      pop;
  logic                      pop_ok;
  logic                      flush;
  logic [DATA_W-1:0]         head_instr;
  logic [DATA_W-1:0]         head_val;
  logic                      head_ready;
  logic                      head_exc;
  logic [TAG_W-1:0]          head_tag;
  logic                      is_full;
  logic                      is_empty;
  logic [CNT_W-1:0]          count;

  always #5 clock = ~clock;

  rob_circ #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_CPL(NUM_CPL)) dut (
    .clock(clock), .reset_n(reset_n), .push(push), .instr_in(instr_in),
    .alloc_tag(alloc_tag), .push_ok(push_ok), .cpl_valid(cpl_valid),
    .cpl_tag(cpl_tag), .cpl_val(cpl_val), .cpl_exc(cpl_exc), .pop(pop),
    .pop_ok(pop_ok), .flush(flush), .head_instr(head_instr), .head_val(head_val),
    .head_ready(head_ready), .head_exc(head_exc), .head_tag(head_tag),
    .is_full(is_full), .is_empty(is_empty), .count(count)
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] instr;
    logic [31:0] val;
    logic        rdy;
    logic        exc;
  } ment_t;

  typedef struct {
    logic        push;
    logic [31:0] instr;
    logic [1:0]  cv;
    logic [1:0]  t0;
    logic [1:0]  t1;
    logic [31:0] v0;
    logic [31:0] v1;
    logic        pop;
    logic        e_push_ok;
    logic        e_pop_ok;
    logic [2:0]  e_count;
    logic [1:0]  e_alloc;
    logic [1:0]  e_htag;
    logic        e_hrdy;
    logic [31:0] e_hval;
  } vec_t;

  ment_t q[$];
  int    mtail;
  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    ment_t h;
    logic  e;
    e = (q.size() == 0);
    h = e ? ment_t'('0) : q[0];
    chk("is_empty",   64'(is_empty),   64'(e));
    chk("is_full",    64'(is_full),    64'(q.size() == DEPTH));
    chk("count",      64'(count),      64'(q.size()));
    chk("alloc_tag",  64'(alloc_tag),  64'(mtail));
    chk("push_ok",    64'(push_ok),    64'(push && !flush && q.size() < DEPTH));
    chk("pop_ok",     64'(pop_ok),     64'(pop && !flush && !e && h.rdy));
    chk("head_tag",   64'(head_tag),   64'(h.tag));
    chk("head_instr", 64'(head_instr), 64'(h.instr));
    chk("head_val",   64'(head_val),   64'(h.val));
    chk("head_ready", 64'(head_ready), 64'(h.rdy));
    chk("head_exc",   64'(head_exc),   64'(h.exc));
  endtask

  task automatic model_step();
    bit    pok, ook;
    ment_t t;
    if (flush) begin
      q.delete();
      mtail = 0;
    end else begin
      pok = push && q.size() < DEPTH;
      ook = pop && q.size() > 0 && q[0].rdy;
      for (int k = 0; k < NUM_CPL; k++) begin
        if (cpl_valid[k]) begin
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].tag == cpl_tag[k*TAG_W +: TAG_W]) begin
              t = q[i];
              t.rdy = 1'b1;
              t.val = cpl_val[k*DATA_W +: DATA_W];
              t.exc = cpl_exc[k];
              q[i] = t;
            end
          end
        end
      end
      if (ook) void'(q.pop_front());
      if (pok) begin
        t.tag   = 2'(mtail);
        t.instr = instr_in;
        t.val   = 32'h0;
        t.rdy   = 1'b0;
        t.exc   = 1'b0;
        q.push_back(t);
        mtail = (mtail + 1) % DEPTH;
      end
    end
  endtask

  task automatic drive(input logic p, input logic [31:0] ins, input logic [1:0] cv,
                       input logic [1:0] t0, input logic [1:0] t1,
                       input logic [31:0] v0, input logic [31:0] v1,
                       input logic [1:0] ce, input logic po, input logic fl);
    @(negedge clock);
    push      = p;
    instr_in  = ins;
    cpl_valid = cv;
    cpl_tag   = {t1, t0};
    cpl_val   = {v1, v0};
    cpl_exc   = ce;
    pop       = po;
    flush     = fl;
  endtask

  task automatic cyc(input logic p, input logic [31:0] ins, input logic [1:0] cv,
                     input logic [1:0] t0, input logic [1:0] t1,
                     input logic [31:0] v0, input logic [31:0] v1,
                     input logic [1:0] ce, input logic po, input logic fl);
    drive(p, ins, cv, t0, t1, v0, v1, ce, po, fl);
    #1;
    check_model();
    model_step();
  endtask

  function automatic vec_t mk(input logic p, input logic [31:0] ins, input logic [1:0] cv,
                              input logic [1:0] t0, input logic [1:0] t1,
                              input logic [31:0] v0, input logic [31:0] v1, input logic po,
                              input logic epu, input logic epo, input logic [2:0] ecnt,
                              input logic [1:0] eal, input logic [1:0] eht,
                              input logic erdy, input logic [31:0] ehv);
    vec_t v;
    v.push = p;  v.instr = ins; v.cv = cv; v.t0 = t0; v.t1 = t1; v.v0 = v0; v.v1 = v1;
    v.pop = po;  v.e_push_ok = epu; v.e_pop_ok = epo; v.e_count = ecnt; v.e_alloc = eal;
    v.e_htag = eht; v.e_hrdy = erdy; v.e_hval = ehv;
    return v;
  endfunction

  initial begin
    int tg0, tg1;
    reset_n = 1'b0; push = 1'b0; instr_in = '0; cpl_valid = '0; cpl_tag = '0;
    cpl_val = '0; cpl_exc = '0; pop = 1'b0; flush = 1'b0;
    mtail = 0;

    // Fill A..D, overfill, out-of-order completion, two-port collision on tag 1.
    tbl[0]  = mk(1'b1, 32'hA, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 32'hB, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 3'd1, 2'd1, 2'd0, 1'b0, 32'h0);
    tbl[2]  = mk(1'b1, 32'hC, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 3'd2, 2'd2, 2'd0, 1'b0, 32'h0);
    tbl[3]  = mk(1'b1, 32'hD, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b0, 1'b1, 1'b0, 3'd3, 2'd3, 2'd0, 1'b0, 32'h0);
    tbl[4]  = mk(1'b1, 32'hE, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b0, 1'b0, 1'b0, 3'd4, 2'd0, 2'd0, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 32'h0, 2'b01, 2'd2, 2'd0, 32'hC0, 32'h0,  1'b1, 1'b0, 1'b0, 3'd4, 2'd0, 2'd0, 1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 32'h0, 2'b01, 2'd0, 2'd0, 32'hA0, 32'h0,  1'b1, 1'b0, 1'b0, 3'd4, 2'd0, 2'd0, 1'b0, 32'h0);
    tbl[7]  = mk(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b1, 3'd4, 2'd0, 2'd0, 1'b1, 32'hA0);
    tbl[8]  = mk(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b0, 3'd3, 2'd0, 2'd1, 1'b0, 32'h0);
    tbl[9]  = mk(1'b0, 32'h0, 2'b11, 2'd1, 2'd1, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0, 3'd3, 2'd0, 2'd1, 1'b0, 32'h0);
    tbl[10] = mk(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b1, 3'd3, 2'd0, 2'd1, 1'b1, 32'h22);
    tbl[11] = mk(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b1, 3'd2, 2'd0, 2'd2, 1'b1, 32'hC0);
    tbl[12] = mk(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0,  32'h0,  1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 2'd3, 1'b0, 32'h0);

    #3;
    chk("rst_is_empty",  64'(is_empty),   64'd1);
    chk("rst_is_full",   64'(is_full),    64'd0);
    chk("rst_count",     64'(count),      64'd0);
    chk("rst_alloc_tag", 64'(alloc_tag),  64'd0);
    chk("rst_head_rdy",  64'(head_ready), 64'd0);
    chk("rst_head_tag",  64'(head_tag),   64'd0);
    chk("rst_head_val",  64'(head_val),   64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].push, tbl[i].instr, tbl[i].cv, tbl[i].t0, tbl[i].t1,
            tbl[i].v0, tbl[i].v1, 2'b00, tbl[i].pop, 1'b0);
      #1;
      check_model();
      chk($sformatf("tbl%0d_push_ok", i),  64'(push_ok),    64'(tbl[i].e_push_ok));
      chk($sformatf("tbl%0d_pop_ok", i),   64'(pop_ok),     64'(tbl[i].e_pop_ok));
      chk($sformatf("tbl%0d_count", i),    64'(count),      64'(tbl[i].e_count));
      chk($sformatf("tbl%0d_alloc", i),    64'(alloc_tag),  64'(tbl[i].e_alloc));
      chk($sformatf("tbl%0d_head_tag", i), 64'(head_tag),   64'(tbl[i].e_htag));
      chk($sformatf("tbl%0d_head_rdy", i), 64'(head_ready), 64'(tbl[i].e_hrdy));
      chk($sformatf("tbl%0d_head_val", i), 64'(head_val),   64'(tbl[i].e_hval));
      model_step();
    end

    // Full buffer with a ready head: push+pop together retires but does not allocate.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h100 + 32'(i), 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 2'b10, 2'd0, 2'd3, 32'h0, 32'hD0, 2'b10, 1'b0, 1'b0);
    drive(1'b1, 32'h55, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    #1;
    check_model();
    chk("full_pp_pop_ok",  64'(pop_ok),  64'd1);
    chk("full_pp_push_ok", 64'(push_ok), 64'd0);
    chk("full_pp_count",   64'(count),   64'd4);
    chk("full_pp_exc",     64'(head_exc), 64'd1);
    model_step();
    cyc(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("full_pp_count_after", 64'(count), 64'd3);

    // Random traffic with wrap-around, biased towards completions that hit live entries.
    for (int n = 0; n < 400; n++) begin
      tg0 = (q.size() > 0 && $urandom_range(3) != 0) ? int'(q[$urandom_range(q.size() - 1)].tag) : int'($urandom_range(3));
      tg1 = (q.size() > 0 && $urandom_range(3) != 0) ? int'(q[$urandom_range(q.size() - 1)].tag) : int'($urandom_range(3));
      cyc(1'($urandom_range(2) != 0), $urandom, 2'($urandom_range(3)), 2'(tg0), 2'(tg1),
          $urandom, $urandom, 2'($urandom_range(3)), 1'($urandom_range(1)),
          1'($urandom_range(49) == 0));
      chk("count_bound", 64'(count <= 3'd4), 64'd1);
    end

    // Flush with three entries plus concurrent push and completion.
    cyc(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(i), 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 32'h299, 2'b01, 2'd0, 2'd0, 32'h77, 32'h0, 2'b01, 1'b1, 1'b1);
    #1;
    check_model();
    chk("flush_push_ok", 64'(push_ok), 64'd0);
    chk("flush_pop_ok",  64'(pop_ok),  64'd0);
    model_step();
    cyc(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    chk("flush_empty", 64'(is_empty),  64'd1);
    chk("flush_count", 64'(count),     64'd0);
    chk("flush_alloc", 64'(alloc_tag), 64'd0);

    // Asynchronous reset in the middle of traffic, checked before any clock edge.
    cyc(1'b1, 32'h300, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 32'h301, 2'b01, 2'd0, 2'd0, 32'h33, 32'h0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    push = 1'b0; pop = 1'b0; cpl_valid = '0; flush = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_is_empty", 64'(is_empty),   64'd1);
    chk("arst_count",    64'(count),      64'd0);
    chk("arst_alloc",    64'(alloc_tag),  64'd0);
    chk("arst_head_rdy", 64'(head_ready), 64'd0);
    chk("arst_head_ins", 64'(head_instr), 64'd0);
    chk("arst_head_val", 64'(head_val),   64'd0);
    q.delete();
    mtail = 0;
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1'b1, 32'h400, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
